// File: rtl/dma_x_stream_bridge_if.sv
// Bus bundle for the DMA-to-FIR X bridge: the DMA-side Wishbone slave port and the FIR-side AXI-Stream master port.
// The bridge uses the slave modport; the DMA/FIR side uses the master modport.
interface dma_x_stream_bridge_if;
    logic        wbs_stb_from_DMA;
    logic        wbs_cyc_from_DMA;
    logic        wbs_we_from_DMA;
    logic [3:0]  wbs_sel_from_DMA;
    logic [31:0] wbs_adr_from_DMA;
    logic [31:0] wbs_dat_from_DMA;
    logic        wbs_ack_to_DMA;
    logic [31:0] wbs_dat_to_DMA;
    logic        tready_from_FIR;
    logic        tvalid_to_FIR;
    logic [31:0] tdata_to_FIR;
    logic        tlast_to_FIR;

    modport slave (
        input  wbs_stb_from_DMA, wbs_cyc_from_DMA, wbs_we_from_DMA,
        input  wbs_sel_from_DMA, wbs_adr_from_DMA, wbs_dat_from_DMA,
        output wbs_ack_to_DMA, wbs_dat_to_DMA,
        input  tready_from_FIR,
        output tvalid_to_FIR, tdata_to_FIR, tlast_to_FIR
    );

    modport master (
        output wbs_stb_from_DMA, wbs_cyc_from_DMA, wbs_we_from_DMA,
        output wbs_sel_from_DMA, wbs_adr_from_DMA, wbs_dat_from_DMA,
        input  wbs_ack_to_DMA, wbs_dat_to_DMA,
        output tready_from_FIR,
        input  tvalid_to_FIR, tdata_to_FIR, tlast_to_FIR
    );
endinterface

// File: rtl/dma_x_stream_bridge.sv
// Wishbone-written X sample FIFO streamed out over AXI-Stream, with a frame-length
// register driving tlast/frame_done and a pollable status word.
module dma_x_stream_bridge #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] ADDR_DATA  = 32'h3000_0080,
    parameter logic [31:0] ADDR_LEN   = 32'h3000_0084,
    parameter logic [31:0] ADDR_STAT  = 32'h3000_0088
) (
    input  logic                          clk,
    input  logic                          rst,
    dma_x_stream_bridge_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   len_q, len_d, beat_q, beat_d, rdat_q, rdat_d, wdata;
    logic          ack_q, ack_d;
    logic          hit_data, hit_len, hit_stat, req, we;
    logic          full, empty, push, pop, last, len_wr;

    assign hit_data = bus.wbs_adr_from_DMA == ADDR_DATA;
    assign hit_len  = bus.wbs_adr_from_DMA == ADDR_LEN;
    assign hit_stat = bus.wbs_adr_from_DMA == ADDR_STAT;
    assign we       = bus.wbs_we_from_DMA;
    // ~ack_q keeps a held strobe from being counted twice
    assign req      = bus.wbs_stb_from_DMA & bus.wbs_cyc_from_DMA
                    & (hit_data | hit_len | hit_stat) & ~ack_q;

    assign full   = count_q == CW'(FIFO_DEPTH);
    assign empty  = count_q == '0;
    // Full is judged on the registered count, so a same-cycle pop never admits a push
    assign push   = req & we & hit_data & ~full;
    assign len_wr = req & we & hit_len;
    assign pop    = ~empty & bus.tready_from_FIR;
    assign last   = ~empty & (len_q != '0) & (beat_q == len_q - 32'd1);

    always_comb begin
        wdata  = '0;
        for (int i = 0; i < 4; i++)
            wdata[8*i +: 8] = bus.wbs_sel_from_DMA[i] ? bus.wbs_dat_from_DMA[8*i +: 8] : 8'h00;

        ack_d  = req & ~(we & hit_data & full);
        rdat_d = '0;
        if (req & ~we) begin
            if (hit_len)       rdat_d = len_q;
            else if (hit_stat) rdat_d = {16'h0, 8'(count_q), 6'h0, full, empty};
        end

        len_d  = len_wr ? bus.wbs_dat_from_DMA : len_q;
        beat_d = beat_q;
        if (len_wr)   beat_d = '0;
        else if (pop) beat_d = last ? '0 : beat_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rdat_q   <= '0;
            ack_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            len_q  <= len_d;
            beat_q <= beat_d;
            rdat_q <= rdat_d;
            ack_q  <= ack_d;
        end
    end

    assign bus.wbs_ack_to_DMA = ack_q;
    assign bus.wbs_dat_to_DMA = rdat_q;
    assign bus.tvalid_to_FIR  = ~empty;
    assign bus.tdata_to_FIR   = mem_q[rd_ptr_q];
    assign bus.tlast_to_FIR   = last;
    assign fifo_count         = count_q;
    assign frame_done         = pop & last;
endmodule

// File: tb/tb_dma_x_stream_bridge.sv
// Directed bench for dma_x_stream_bridge: a queue-based model checked every cycle,
// plus literal expectations on the accepted AXIS beats and register reads.
module tb_dma_x_stream_bridge;
    localparam int          D      = 8;
    localparam logic [31:0] A_DATA = 32'h3000_0080;
    localparam logic [31:0] A_LEN  = 32'h3000_0084;
    localparam logic [31:0] A_STAT = 32'h3000_0088;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] fifo_count;
    logic       frame_done;

    always #5 clk = ~clk;

    dma_x_stream_bridge_if bus ();

    dma_x_stream_bridge #(.FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a queue of words the FIR still has to receive, plus length/beat bookkeeping
    logic [31:0] mq[$];
    logic [31:0] m_len, m_beat, m_rdat, r_w, nrdat;
    logic        m_ack, nack, r_req, r_pop, r_tl, r_acc, r_lwr, r_hit;

    initial begin
        mq.delete(); m_len = 0; m_beat = 0; m_rdat = 0; m_ack = 0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete(); m_len = 0; m_beat = 0; m_rdat = 0; m_ack = 0;
            end else begin
                r_hit = bus.wbs_adr_from_DMA inside {A_DATA, A_LEN, A_STAT};
                r_req = bus.wbs_stb_from_DMA && bus.wbs_cyc_from_DMA && r_hit && !m_ack;
                r_pop = (mq.size() != 0) && bus.tready_from_FIR;
                r_tl  = r_pop && (m_len != 0) && (m_beat == m_len - 1);
                nack = 0; nrdat = 0; r_acc = 0; r_lwr = 0; r_w = 0;
                if (r_req) begin
                    if (bus.wbs_we_from_DMA && bus.wbs_adr_from_DMA == A_DATA) begin
                        if (mq.size() < D) begin
                            r_acc = 1; nack = 1;
                            for (int i = 0; i < 4; i++)
                                r_w[8*i +: 8] = bus.wbs_sel_from_DMA[i] ? bus.wbs_dat_from_DMA[8*i +: 8] : 8'h00;
                        end
                    end else begin
                        nack = 1;
                        if (!bus.wbs_we_from_DMA) begin
                            if (bus.wbs_adr_from_DMA == A_LEN) nrdat = m_len;
                            else if (bus.wbs_adr_from_DMA == A_STAT)
                                nrdat = {16'h0, 8'(mq.size()), 6'h0, mq.size() == D, mq.size() == 0};
                        end else if (bus.wbs_adr_from_DMA == A_LEN) r_lwr = 1;
                    end
                end
                if (r_pop) begin
                    void'(mq.pop_front());
                    m_beat = r_tl ? 0 : m_beat + 1;
                end
                if (r_lwr) begin m_len = bus.wbs_dat_from_DMA; m_beat = 0; end
                if (r_acc) mq.push_back(r_w);
                m_ack  = nack;
                m_rdat = nrdat;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    logic e_tl;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("ack", 32'(bus.wbs_ack_to_DMA), 32'(m_ack));
            chk("rdata", bus.wbs_dat_to_DMA, m_rdat);
            chk("tvalid", 32'(bus.tvalid_to_FIR), 32'(mq.size() != 0));
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            e_tl = (mq.size() != 0) && (m_len != 0) && (m_beat == m_len - 1);
            if (mq.size() != 0) chk("tdata", bus.tdata_to_FIR, mq[0]);
            chk("tlast", 32'(bus.tlast_to_FIR), 32'(e_tl));
            chk("frame_done", 32'(frame_done), 32'(e_tl && bus.tready_from_FIR));
        end
    end

    // Log of accepted beats {tlast, tdata} and frame_done pulses
    logic [32:0] blog[$];
    int          fd_cnt = 0;
    initial forever begin
        @(posedge clk);
        if (rst) begin
            if (bus.tvalid_to_FIR && bus.tready_from_FIR)
                blog.push_back({bus.tlast_to_FIR, bus.tdata_to_FIR});
            if (frame_done) fd_cnt++;
        end
    end

    task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
        int n = 0;
        bus.wbs_stb_from_DMA = 1; bus.wbs_cyc_from_DMA = 1; bus.wbs_we_from_DMA = we;
        bus.wbs_adr_from_DMA = adr; bus.wbs_dat_from_DMA = dat; bus.wbs_sel_from_DMA = sel;
        do begin @(posedge clk); #1; n++; end while (!bus.wbs_ack_to_DMA && n < 40);
        if (!bus.wbs_ack_to_DMA) begin
            n_chk++; n_fail++;
            $display("FAIL wb_timeout adr %h: no ack after %0d cycles, ack required", adr, n);
        end
        rd = bus.wbs_dat_to_DMA;
        bus.wbs_stb_from_DMA = 0; bus.wbs_cyc_from_DMA = 0; bus.wbs_we_from_DMA = 0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] dummy;
        wb(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] v;
        wb(1'b0, adr, 32'h0, 4'hF, v);
        chk(nm, v, exp);
    endtask

    task automatic drain();
        int n = 0;
        bus.tready_from_FIR = 1;
        while (fifo_count != 0 && n < 100) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 32'(fifo_count), 32'd0);
    endtask

    logic stop;
    int   base, fd0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wbs_stb_from_DMA = 0; bus.wbs_cyc_from_DMA = 0; bus.wbs_we_from_DMA = 0;
        bus.wbs_sel_from_DMA = 0; bus.wbs_adr_from_DMA = 0; bus.wbs_dat_from_DMA = 0;
        bus.tready_from_FIR = 0; stop = 0;
        #2;
        chk("rst_tvalid", 32'(bus.tvalid_to_FIR), 32'd0);
        chk("rst_ack", 32'(bus.wbs_ack_to_DMA), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;

        // Basic frame of three with tlast on the third
        bus.tready_from_FIR = 1;
        base = blog.size(); fd0 = fd_cnt;
        wr(A_LEN, 32'd3);
        wr(A_DATA, 32'h11); wr(A_DATA, 32'h22); wr(A_DATA, 32'h33);
        repeat (4) @(posedge clk); #1;
        chk("t1_nbeats", 32'(blog.size() - base), 32'd3);
        if (blog.size() >= base + 3) begin
            chk("t1_b0", blog[base][31:0], 32'h11);   chk("t1_l0", 32'(blog[base][32]), 32'd0);
            chk("t1_b1", blog[base+1][31:0], 32'h22); chk("t1_l1", 32'(blog[base+1][32]), 32'd0);
            chk("t1_b2", blog[base+2][31:0], 32'h33); chk("t1_l2", 32'(blog[base+2][32]), 32'd1);
        end
        chk("t1_frames", 32'(fd_cnt - fd0), 32'd1);

        // Fill to full, stall the ninth write, free one slot
        bus.tready_from_FIR = 0;
        wr(A_LEN, 32'd0);
        base = blog.size();
        for (int i = 1; i <= 8; i++) wr(A_DATA, 32'h100 + 32'(i));
        rd_chk("t2_stat_full", A_STAT, 32'h0000_0802);
        fork
            wr(A_DATA, 32'h109);
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("t2_stall_count", 32'(fifo_count), 32'd8);
                chk("t2_stall_noack", 32'(bus.wbs_ack_to_DMA), 32'd0);
                bus.tready_from_FIR = 1;
                @(posedge clk); #1;
                bus.tready_from_FIR = 0;
            end
        join
        drain();
        chk("t2_nbeats", 32'(blog.size() - base), 32'd9);
        if (blog.size() >= base + 9)
            for (int i = 0; i < 9; i++) chk("t2_order", blog[base+i][31:0], 32'h101 + 32'(i));

        // Ready toggling every cycle while pushing a five-beat frame
        wr(A_LEN, 32'd5);
        base = blog.size(); fd0 = fd_cnt;
        bus.tready_from_FIR = 0; stop = 0;
        fork
            while (!stop) begin @(posedge clk); #1; bus.tready_from_FIR = ~bus.tready_from_FIR; end
            begin
                for (int i = 0; i < 5; i++) wr(A_DATA, 32'h200 + 32'(i));
                stop = 1;
            end
        join
        drain();
        chk("t3_nbeats", 32'(blog.size() - base), 32'd5);
        if (blog.size() >= base + 5)
            for (int i = 0; i < 5; i++) begin
                chk("t3_data", blog[base+i][31:0], 32'h200 + 32'(i));
                chk("t3_last", 32'(blog[base+i][32]), 32'(i == 4));
            end
        chk("t3_frames", 32'(fd_cnt - fd0), 32'd1);

        // Byte-select masking
        wr(A_LEN, 32'd0);
        base = blog.size();
        wr(A_DATA, 32'hAABB_CCDD, 4'b0101);
        repeat (3) @(posedge clk); #1;
        chk("t4_nbeats", 32'(blog.size() - base), 32'd1);
        if (blog.size() > base) chk("t4_masked", blog[base][31:0], 32'h00BB_00DD);

        // Length rewrite mid-frame restarts the beat count
        wr(A_LEN, 32'd4);
        base = blog.size(); fd0 = fd_cnt;
        wr(A_DATA, 32'h301); wr(A_DATA, 32'h302);
        repeat (3) @(posedge clk); #1;
        wr(A_LEN, 32'd2);
        wr(A_DATA, 32'h303); wr(A_DATA, 32'h304); wr(A_DATA, 32'h305);
        repeat (4) @(posedge clk); #1;
        chk("t5_nbeats", 32'(blog.size() - base), 32'd5);
        if (blog.size() >= base + 5) begin
            chk("t5_l2", 32'(blog[base+2][32]), 32'd0);
            chk("t5_l3", 32'(blog[base+3][32]), 32'd1);
            chk("t5_d3", blog[base+3][31:0], 32'h304);
            chk("t5_l4", 32'(blog[base+4][32]), 32'd0);
        end
        chk("t5_frames", 32'(fd_cnt - fd0), 32'd1);
        rd_chk("t5_len", A_LEN, 32'd2);

        // Asynchronous reset with three words queued and an ack in flight
        bus.tready_from_FIR = 0;
        wr(A_LEN, 32'd4);
        wr(A_DATA, 32'h401); wr(A_DATA, 32'h402); wr(A_DATA, 32'h403);
        @(posedge clk); #1;
        bus.wbs_stb_from_DMA = 1; bus.wbs_cyc_from_DMA = 1; bus.wbs_we_from_DMA = 1;
        bus.wbs_adr_from_DMA = A_DATA; bus.wbs_dat_from_DMA = 32'h404; bus.wbs_sel_from_DMA = 4'hF;
        @(posedge clk); #1;
        chk("t6_ack_before", 32'(bus.wbs_ack_to_DMA), 32'd1);
        #1 rst = 0;
        #1;
        chk("t6_tvalid", 32'(bus.tvalid_to_FIR), 32'd0);
        chk("t6_ack", 32'(bus.wbs_ack_to_DMA), 32'd0);
        chk("t6_count", 32'(fifo_count), 32'd0);
        chk("t6_frame_done", 32'(frame_done), 32'd0);
        bus.wbs_stb_from_DMA = 0; bus.wbs_cyc_from_DMA = 0; bus.wbs_we_from_DMA = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rd_chk("t6_stat", A_STAT, 32'h0000_0001);
        rd_chk("t6_len", A_LEN, 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_x_stream_bridge.md
Name: dma_x_stream_bridge

Overview:
Wishbone slave that receives the DMA's single-word writes of X samples, addressed to 0x30000080, and buffers them in a synchronous FIFO. It drives them out as an AXI-Stream master into the FIR X input. The block sits between the DMA's FIR-side Wishbone master and the FIR's AXI-Stream slave port. It also holds the frame length so that tlast is raised on the final sample of each frame, and exposes FIFO status for CPU polling.

Parameters:
FIFO_DEPTH, 8, number of 32-bit FIFO entries (power of two, ≥2)
ADDR_DATA, 32'h30000080, write port for X samples (FIFO push)
ADDR_LEN, 32'h30000084, frame length register (R/W)
ADDR_STAT, 32'h30000088, status register (read-only)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
wbs_stb_from_DMA  in  1  Wishbone strobe
wbs_cyc_from_DMA  in  1  Wishbone cycle
wbs_we_from_DMA  in  1  write enable
wbs_sel_from_DMA  in  4  byte selects
wbs_adr_from_DMA  in  32  address
wbs_dat_from_DMA  in  32  write data
wbs_ack_to_DMA  out  1  acknowledge, one-cycle pulse
wbs_dat_to_DMA  out  32  read data
tready_from_FIR  in  1  AXIS ready
tvalid_to_FIR  out  1  AXIS valid
tdata_to_FIR  out  32  AXIS data
tlast_to_FIR  out  1  AXIS last
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_done  out  1  one-cycle pulse when the tlast beat is accepted

Behaviour:
Reset (rst=0, asynchronous):
- All registered outputs go to 0.
- FIFO pointers and count go to 0; len_reg=0; beat_cnt=0.
- tvalid_to_FIR=0 immediately. No partial transfer survives reset.

Wishbone decode:
- req = stb & cyc & (adr ∈ {ADDR_DATA, ADDR_LEN, ADDR_STAT}) & ~wbs_ack_to_DMA.
- Addresses outside the decoded set are never acked (another slave owns them).

Ack timing, registered:
- A request seen in cycle N is acked in cycle N+1.
- ack is high for exactly one cycle. The cycle after ack, a still-asserted stb is a new request.

Data writes:
- A write to ADDR_DATA is accepted only when fifo_count < FIFO_DEPTH, evaluated on the registered count.
- While the FIFO is full there is no ack: wait states until a pop frees an entry. The push happens at the same edge that raises ack.
- Pushed word = wbs_dat_from_DMA with unselected bytes (sel bit 0) forced to 0.
- A read of ADDR_DATA acks with wbs_dat_to_DMA=0 and does not pop.

Length register:
- A write to ADDR_LEN loads len_reg with the full 32 bits (sel ignored) and clears beat_cnt.
- A read of ADDR_LEN returns len_reg.

Status register:
- A read of ADDR_STAT returns {16'h0, count zero-extended to 8 bits in [15:8], 6'h0, full in [1], empty in [0]}.
- Writes to ADDR_STAT are acked and ignored.

wbs_dat_to_DMA:
- Valid in the ack cycle only; 0 otherwise.

AXIS output (FIFO head driven directly):
- tvalid_to_FIR = ~empty; tdata_to_FIR = head entry.
- Pop occurs on tvalid & tready.
- tdata/tvalid must not change while tvalid=1 and tready=0.

Write-through latency:
- No bypass. A word pushed at edge E is first visible on tvalid after E, i.e. next cycle at minimum.

Simultaneous push and pop:
- Both occur; count is unchanged.
- When full, a push is not accepted in the same cycle as a pop. The pending request is acked the cycle after the pop.

tlast:
- tlast_to_FIR = tvalid & (len_reg ≠ 0) & (beat_cnt == len_reg−1).
- On each accepted beat, beat_cnt increments. It wraps to 0 after the tlast beat; frame_done pulses in that same cycle.
- len_reg=0: tlast is never asserted and beat_cnt free-runs, wrapping at 2^32.

Mid-frame length write:
- A length write while beats are in flight takes effect immediately; counting restarts from 0 for the next accepted beat.
- If the length write and a beat acceptance happen in the same cycle, the clear wins: beat_cnt=0.

FIFO wrap:
- Pointers wrap modulo FIFO_DEPTH.
- full = (count == FIFO_DEPTH); empty = (count == 0).

Test Plan:
1. Write len=3, then push 0x11, 0x22, 0x33 with tready=1 → three AXIS beats 0x11, 0x22, 0x33; tlast only on 0x33; frame_done pulses once; each ack is exactly 1 cycle after stb.
2. tready=0, FIFO_DEPTH=8, nine pushes → first 8 acked; 9th stalls; status read shows full=1, count=8. Raise tready for one cycle → 9th acked the next cycle; tdata order preserved.
3. Toggle tready 1,0,1,0 while pushing 5 words with len=5 → tdata/tvalid stable while tready=0; no loss or duplication; tlast on the 5th beat.
4. Push 0xAABBCCDD with sel=4'b0101 → FIR receives 0x00BB00DD.
5. len=4; after 2 beats write len=2; push 3 more words → tlast on the 2nd beat after the rewrite (overall beat 4), and beat_cnt wraps to 0.
6. Drive rst low asynchronously mid-frame, with FIFO holding 3 words and an ack pending → tvalid, ack, count, len and frame_done are 0 immediately; after release, status reads 0x00000001.
